// File: rtl/fp_norm_pack_if.sv
// ---------------------------------------------------------------------------
// fp_norm_pack_if
//   Bundles the upstream (raw sum) and downstream (packed word) handshakes of
//   the fp normalise/pack stage.
//
//   Upstream side:
//     in_valid   beat valid                     (master -> slave)
//     in_ready   stage can accept a beat        (slave  -> master)
//     in_sign    result sign                    (master -> slave)
//     in_exp     pre-normalise biased exponent  (master -> slave)
//     in_mant    {carry, hidden, fraction}      (master -> slave)
//   Downstream side:
//     out_valid  packed result valid            (slave  -> master)
//     out_ready  consumer accepts result        (master -> slave)
//     out_data   {sign, exp, frac}              (slave  -> master)
//     out_flags  {ovf, unf, zero}               (slave  -> master)
//
//   The master modport belongs to whoever feeds the stage and consumes its
//   result; the slave modport belongs to fp_norm_pack.
// ---------------------------------------------------------------------------
interface fp_norm_pack_if #(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 24
);

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EW-1:0]     in_exp;
    logic [MW:0]       in_mant;

    logic              out_valid;
    logic              out_ready;
    logic [EW+MW-1:0]  out_data;
    logic [2:0]        out_flags;

    modport master (
        output in_valid,
        output in_sign,
        output in_exp,
        output in_mant,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_flags,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_sign,
        input  in_exp,
        input  in_mant,
        output in_ready,
        output out_valid,
        output out_data,
        output out_flags,
        input  out_ready
    );

endinterface

// File: rtl/fp_norm_pack.sv
// ---------------------------------------------------------------------------
// fp_norm_pack
//   Last stage of the fp add/sub datapath. Takes the raw aligned sum
//   (sign, pre-normalise exponent, magnitude with carry-out), renormalises it
//   and packs an IEEE-754-style word with overflow/underflow/zero flags.
//   Rounding is truncation; denormal results flush to signed zero.
//
//   Pipeline (all stages advance together on the shared enable):
//     S1  register the beat and its leading-zero count / zero detect
//     S2  shift the mantissa and adjust the exponent (signed, EW+2 bits)
//     S3  classify and pack into the output registers
//
// Ports
//   clk   clock, all state on posedge
//   rst   asynchronous, active-high reset
//   bus   fp_norm_pack_if.slave: in_* handshake/beat, out_* handshake/result
//
// Parameters
//   EW    exponent width (bias 2**(EW-1)-1, all-ones exponent = Inf)
//   MW    mantissa width including hidden bit
// ---------------------------------------------------------------------------
module fp_norm_pack #(
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 24
) (
    input logic          clk,
    input logic          rst,
    fp_norm_pack_if.slave bus
);

    localparam int unsigned LzW = $clog2(MW);
    localparam int unsigned XW  = EW + 2;
    localparam int unsigned DW  = EW + MW;

    // Exponent thresholds for classification in S3.
    localparam logic signed [XW-1:0] ExpZero = '0;
    localparam logic signed [XW-1:0] ExpInf  = XW'((2 ** EW) - 1);

    // -----------------------------------------------------------------------
    // Flow control: a single global enable. The whole pipe stalls only when
    // the output holds an unaccepted beat, so bubbles are never squeezed.
    // -----------------------------------------------------------------------
    logic           out_valid_q;
    logic [DW-1:0]  out_data_q;
    logic [2:0]     out_flags_q;
    logic           en;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    // -----------------------------------------------------------------------
    // S1: leading-zero count and zero detect on the incoming beat
    // -----------------------------------------------------------------------
    logic [LzW-1:0] lz_d;
    logic           zero_d;

    always_comb begin
        lz_d   = '0;
        zero_d = (bus.in_mant == '0);
        // Ascending scan: the highest set bit is the last to write lz_d.
        for (int i = 0; i < int'(MW); i++) begin
            if (bus.in_mant[i]) begin
                lz_d = LzW'(int'(MW) - 1 - i);
            end
        end
    end

    logic           s1_valid_q;
    logic           s1_sign_q;
    logic [EW-1:0]  s1_exp_q;
    logic [MW:0]    s1_mant_q;
    logic [LzW-1:0] s1_lz_q;
    logic           s1_zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_lz_q    <= '0;
            s1_zero_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= bus.in_valid;
            // Data registers only load on a real beat; a bubble keeps them stale.
            if (bus.in_valid) begin
                s1_sign_q <= bus.in_sign;
                s1_exp_q  <= bus.in_exp;
                s1_mant_q <= bus.in_mant;
                s1_lz_q   <= lz_d;
                s1_zero_q <= zero_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S2: renormalise. Only the fraction below the hidden bit is kept, since
    // after normalisation the hidden bit is implicit.
    // -----------------------------------------------------------------------
    logic                 s1_carry;
    logic signed [XW-1:0] exp_ext;
    logic signed [XW-1:0] lz_ext;
    logic [MW-2:0]        s2_frac_d;
    logic signed [XW-1:0] s2_exp_d;

    assign s1_carry = s1_mant_q[MW];

    always_comb begin
        exp_ext = {2'b00, s1_exp_q};
        lz_ext  = XW'(s1_lz_q);
        if (s1_carry) begin
            // Carry-out: shift right one, the dropped LSB is truncated.
            s2_frac_d = s1_mant_q[MW-1:1];
            s2_exp_d  = exp_ext + XW'(1);
        end else begin
            // Bits shifted past the hidden position vanish with the hidden bit.
            s2_frac_d = s1_mant_q[MW-2:0] << s1_lz_q;
            s2_exp_d  = exp_ext - lz_ext;
        end
    end

    logic                 s2_valid_q;
    logic                 s2_sign_q;
    logic                 s2_zero_q;
    logic signed [XW-1:0] s2_exp_q;
    logic [MW-2:0]        s2_frac_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
        end else if (en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_exp_q  <= s2_exp_d;
                s2_frac_q <= s2_frac_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // S3: classify and pack. Order matters: zero, then underflow, then
    // overflow, then a normal number.
    // -----------------------------------------------------------------------
    logic [DW-1:0] data_d;
    logic [2:0]    flags_d;

    always_comb begin
        data_d  = {s2_sign_q, s2_exp_q[EW-1:0], s2_frac_q};
        flags_d = 3'b000;
        if (s2_zero_q) begin
            // Exact cancellation always yields +0.
            data_d  = '0;
            flags_d = 3'b001;
        end else if (s2_exp_q <= ExpZero) begin
            data_d         = '0;
            data_d[DW-1]   = s2_sign_q;
            flags_d        = 3'b010;
        end else if (s2_exp_q >= ExpInf) begin
            data_d  = {s2_sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
            flags_d = 3'b100;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q  <= data_d;
                out_flags_q <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_pack.sv
// ---------------------------------------------------------------------------
// tb_fp_norm_pack
//   Scoreboard bench for fp_norm_pack. Drivers push the expected packed word
//   when a beat is accepted; a monitor pops and compares on every output
//   transfer, and also watches hold-stability and in_ready while stalled.
// ---------------------------------------------------------------------------
module tb_fp_norm_pack;

    localparam int unsigned EW = 8;
    localparam int unsigned MW = 24;
    localparam int unsigned DW = EW + MW;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    flags;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fp_norm_pack_if #(.EW(EW), .MW(MW)) bus ();

    fp_norm_pack #(.EW(EW), .MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   pops   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: locate the MSB of the whole magnitude, rescale it so the MSB
    // sits at the hidden-bit position, and move the exponent by the same amount.
    function automatic exp_t model(input logic s, input int e, input int m);
        exp_t   r;
        int     msb;
        int     ne;
        longint norm;
        logic [MW-2:0] frac;
        r.acc_cyc = 0;
        r.chk_lat = 1'b0;
        if (m == 0) begin
            r.data  = '0;
            r.flags = 3'b001;
            return r;
        end
        msb = $clog2(m + 1) - 1;
        ne  = e + msb - (int'(MW) - 1);
        if (msb >= int'(MW) - 1) norm = longint'(m) >> (msb - (int'(MW) - 1));
        else                     norm = longint'(m) << ((int'(MW) - 1) - msb);
        frac = norm[MW-2:0];
        if (ne <= 0) begin
            r.data  = {s, {(DW-1){1'b0}}};
            r.flags = 3'b010;
        end else if (ne >= (2 ** EW) - 1) begin
            r.data  = {s, {EW{1'b1}}, {(MW-1){1'b0}}};
            r.flags = 3'b100;
        end else begin
            r.data  = {s, EW'(ne), frac};
            r.flags = 3'b000;
        end
        return r;
    endfunction

    // Present a beat from the negedge; sample acceptance just before the next
    // posedge and record the expected result at that point.
    task automatic send(input logic s, input logic [EW-1:0] e, input logic [MW:0] m,
                        input logic [DW-1:0] xd, input logic [2:0] xf, input bit lat);
        exp_t x;
        bit   done = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        for (int n = 0; n < 200 && !done; n++) begin
            #4;
            if (rst) break;
            if (bus.in_ready) begin
                x.data    = xd;
                x.flags   = xf;
                x.acc_cyc = cyc;
                x.chk_lat = lat;
                sb.push_back(x);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done && !rst) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1 within 200 cycles",
                     bus.in_ready);
        end
    endtask

    task automatic send_rand(input bit lat);
        logic          s;
        logic [EW-1:0] e;
        logic [MW:0]   m;
        exp_t          x;
        s = 1'($urandom());
        case ($urandom_range(0, 3))
            0:       e = EW'($urandom_range(0, 30));
            1:       e = EW'($urandom_range(225, 255));
            default: e = EW'($urandom());
        endcase
        m = (MW+1)'($urandom());
        m = m >> $urandom_range(0, MW + 1);
        x = model(s, int'(e), int'(m));
        send(s, e, m, x.data, x.flags, lat);
    endtask

    task automatic drop();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 1000; n++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    endtask

    task automatic wait_pops(input int target);
        for (int n = 0; n < 500; n++) begin
            if (pops >= target) return;
            @(posedge clk);
        end
        checks++;
        errors++;
        $display("FAIL pop_timeout: %0d outputs seen, expected %0d", pops, target);
    endtask

    // Monitor: samples 1 time unit before each posedge.
    initial begin
        bit            stall = 1'b0;
        logic [DW-1:0] pd;
        logic [2:0]    pf;
        exp_t          x;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'({bus.out_data, bus.out_flags}), 64'({pd, pf}));
            end
            stall = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                check("in_ready_stall", 64'(bus.in_ready), 64'd0);
                stall = 1'b1;
                pd    = bus.out_data;
                pf    = bus.out_flags;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no output", bus.out_data);
                end else begin
                    x = sb.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(x.data));
                    check("out_flags", 64'(bus.out_flags), 64'(x.flags));
                    if (x.chk_lat) check("latency", 64'(cyc - x.acc_cyc), 64'd3);
                    pops++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit rdone;
        int base;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;

        // Directed values, back to back, with hand-derived results.
        send(1'b0, 8'd127, 25'h1000000, 32'h40000000, 3'b000, 1'b1);
        send(1'b0, 8'd127, 25'h0000001, 32'h34000000, 3'b000, 1'b1);
        send(1'b1, 8'd90,  25'h0000000, 32'h00000000, 3'b001, 1'b1);
        send(1'b1, 8'd5,   25'h0000100, 32'h80000000, 3'b010, 1'b1);
        send(1'b0, 8'd254, 25'h1800000, 32'h7F800000, 3'b100, 1'b1);
        send(1'b0, 8'd253, 25'h1800000, 32'h7F400000, 3'b000, 1'b1);
        send(1'b1, 8'd255, 25'h0800000, 32'hFF800000, 3'b100, 1'b1);
        send(1'b0, 8'd1,   25'h0FFFFFF, 32'h00FFFFFF, 3'b000, 1'b1);
        send(1'b1, 8'd1,   25'h0400000, 32'h80000000, 3'b010, 1'b1);
        send(1'b0, 8'd254, 25'h0FFFFFF, 32'h7F7FFFFF, 3'b000, 1'b1);
        send(1'b0, 8'd127, 25'h1FFFFFF, 32'h407FFFFF, 3'b000, 1'b1);
        drop();
        drain();

        // Random beats with random bubbles and random back-pressure.
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) drop();
                    send_rand(1'b0);
                end
                drop();
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Stream of 8, stall 4 cycles mid-stream, reset after 5 outputs.
        base = pops;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (!rst) send_rand(1'b0);
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                wait_pops(base + 2);
                @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
            begin
                wait_pops(base + 5);
                @(negedge clk);
                rst = 1'b1;
                sb.delete();
                #1;
                check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
                check("midrst_out_data", 64'(bus.out_data), 64'd0);
                check("midrst_out_flags", 64'(bus.out_flags), 64'd0);
            end
        join
        check("stream_pops", 64'(pops - base), 64'd5);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #4;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (8) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
